// File: rtl/wb_merge.sv
// Write-back merge: in-order pipeline writes win the regfile port; long-latency
// results queue in a small FIFO with WAW kill, pending-read flags and anti-starvation stall.
module wb_merge #(
  parameter int DEPTH      = 4,
  parameter int DEPTH_LOG2 = 2,
  parameter int STARVE_MAX = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wreg_i,
  input  logic [4:0]            wd_i,
  input  logic [31:0]           wdata_i,
  input  logic                  lu_valid_i,
  output logic                  lu_ready_o,
  input  logic [4:0]            lu_wd_i,
  input  logic [31:0]           lu_wdata_i,
  input  logic                  re1_i,
  input  logic                  re2_i,
  input  logic [4:0]            raddr1_i,
  input  logic [4:0]            raddr2_i,
  output logic                  pend1_o,
  output logic                  pend2_o,
  output logic                  stall_o,
  output logic                  we_o,
  output logic [4:0]            waddr_o,
  output logic [31:0]           wdata_o,
  output logic [DEPTH_LOG2:0]   count_o
);

  localparam int SW = $clog2(STARVE_MAX + 1);

  logic [4:0]            addr_q [DEPTH];
  logic [31:0]           data_q [DEPTH];
  logic [DEPTH-1:0]      kill_q, kill_d, vld;
  logic [DEPTH_LOG2-1:0] head_q, head_d, tail_q, tail_d;
  logic [DEPTH_LOG2:0]   count_q, count_d;
  logic [SW-1:0]         starve_q, starve_d;
  logic                  stall_q, stall_d;

  logic empty, full, head_kill, head_live, pop, push, pipe_kill;

  assign empty      = (count_q == '0);
  assign full       = (count_q == (DEPTH_LOG2+1)'(DEPTH));
  assign head_kill  = kill_q[head_q];
  assign head_live  = !empty && !head_kill;
  // Killed heads drain even under a pipeline write; live heads only when the port is free.
  assign pop        = !empty && (head_kill || !wreg_i);
  assign push       = lu_valid_i && !full && (lu_wd_i != 5'd0);
  assign pipe_kill  = wreg_i && (wd_i != 5'd0);

  assign lu_ready_o = !full;
  assign count_o    = count_q;
  assign stall_o    = stall_q;

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      vld[i] = {1'b0, DEPTH_LOG2'(i) - head_q} < count_q;
    end
  end

  always_comb begin
    we_o    = 1'b0;
    waddr_o = 5'd0;
    wdata_o = 32'd0;
    if (!rst) begin
      if (wreg_i) begin
        we_o    = 1'b1;
        waddr_o = wd_i;
        wdata_o = wdata_i;
      end else if (head_live) begin
        we_o    = 1'b1;
        waddr_o = addr_q[head_q];
        wdata_o = data_q[head_q];
      end
    end
  end

  always_comb begin
    pend1_o = 1'b0;
    pend2_o = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (vld[i] && !kill_q[i]) begin
        if (addr_q[i] == raddr1_i) pend1_o = 1'b1;
        if (addr_q[i] == raddr2_i) pend2_o = 1'b1;
      end
    end
    pend1_o = pend1_o && re1_i && (raddr1_i != 5'd0);
    pend2_o = pend2_o && re2_i && (raddr2_i != 5'd0);
  end

  always_comb begin
    kill_d = kill_q;
    for (int i = 0; i < DEPTH; i++) begin
      if (vld[i] && pipe_kill && (addr_q[i] == wd_i)) kill_d[i] = 1'b1;
    end
    if (push) kill_d[tail_q] = 1'b0;
    head_d  = pop  ? head_q + DEPTH_LOG2'(1) : head_q;
    tail_d  = push ? tail_q + DEPTH_LOG2'(1) : tail_q;
    count_d = count_q + (DEPTH_LOG2+1)'(push) - (DEPTH_LOG2+1)'(pop);
  end

  always_comb begin
    starve_d = starve_q;
    stall_d  = 1'b0;
    if (empty || pop) begin
      starve_d = '0;
    end else if (starve_q == SW'(STARVE_MAX - 1)) begin
      starve_d = '0;
      stall_d  = 1'b1;
    end else begin
      starve_d = starve_q + SW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      kill_q   <= '0;
      head_q   <= '0;
      tail_q   <= '0;
      count_q  <= '0;
      starve_q <= '0;
      stall_q  <= 1'b0;
    end else begin
      kill_q   <= kill_d;
      head_q   <= head_d;
      tail_q   <= tail_d;
      count_q  <= count_d;
      starve_q <= starve_d;
      stall_q  <= stall_d;
    end
  end

  // Payload storage needs no reset: validity is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_q[tail_q] <= lu_wd_i;
      data_q[tail_q] <= lu_wdata_i;
    end
  end

endmodule
